// File: rtl/alu_pkg.sv
// Shared opcode encoding and response-holding FSM state for the ALU arbiter.
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_MUL  = 4'd2;
  localparam logic [OPW-1:0] OP_INC  = 4'd3;
  localparam logic [OPW-1:0] OP_DEC  = 4'd4;
  localparam logic [OPW-1:0] OP_BUF  = 4'd5;
  localparam logic [OPW-1:0] OP_NOT  = 4'd6;
  localparam logic [OPW-1:0] OP_AND  = 4'd7;
  localparam logic [OPW-1:0] OP_OR   = 4'd8;
  localparam logic [OPW-1:0] OP_XOR  = 4'd9;
  localparam logic [OPW-1:0] OP_NAND = 4'd10;
  localparam logic [OPW-1:0] OP_NOR  = 4'd11;
  localparam logic [OPW-1:0] OP_XNOR = 4'd12;
  localparam logic [OPW-1:0] OP_SHL  = 4'd13;
  localparam logic [OPW-1:0] OP_SHR  = 4'd14;
  localparam logic [OPW-1:0] OP_DIV  = 4'd15;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU datapath shared by all requesters.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  // One extra bit so the limit itself is representable for any WIDTH.
  localparam logic [WIDTH:0] SHIFT_LIMIT = (WIDTH+1)'(WIDTH);

  logic shift_oob;

  // Decode opcode into the result; shifts past the width and divide-by-zero are special-cased.
  always_comb begin
    result    = '0;
    div_zero  = 1'b0;
    shift_oob = ({1'b0, b} >= SHIFT_LIMIT);
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_INC:  result = a + WIDTH'(1);
      OP_DEC:  result = a - WIDTH'(1);
      OP_BUF:  result = a;
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_SHL:  result = shift_oob ? '0 : (a << b);
      OP_SHR:  result = shift_oob ? '0 : (a >> b);
      OP_DIV: begin
        if (b == '0) begin
          result   = '1;
          div_zero = 1'b1;
        end else begin
          result = a / b;
        end
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single ALU with a one-entry response register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_opcode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_err
);

  state_t           state;
  state_t           state_n;
  logic             ptr;
  logic             grant;
  logic             gnt_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_code;
  logic [WIDTH-1:0] core_result;
  logic             core_div_zero;

  // Grant selection, ready generation and next-state; the slot frees up in the same cycle rsp_ready drains it.
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    gnt_id    = ptr;
    req_ready = '0;
    if (!rst && (state == EMPTY || rsp_ready) && (req_valid[0] || req_valid[1])) begin
      grant = 1'b1;
      if (req_valid[0] && req_valid[1]) gnt_id = ptr;
      else                              gnt_id = req_valid[1];
      req_ready[gnt_id] = 1'b1;
    end
    case (state)
      EMPTY:   if (grant) state_n = FULL;
      FULL:    if (rsp_ready && !grant) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  // Route the granted requester's operands into the shared datapath.
  always_comb begin
    op_a    = gnt_id ? req_a[WIDTH +: WIDTH]   : req_a[0 +: WIDTH];
    op_b    = gnt_id ? req_b[WIDTH +: WIDTH]   : req_b[0 +: WIDTH];
    op_code = gnt_id ? req_opcode[OPW +: OPW]  : req_opcode[0 +: OPW];
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (op_a),
    .b        (op_b),
    .opcode   (op_code),
    .result   (core_result),
    .div_zero (core_div_zero)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  // Response holding register and round-robin pointer; both only change on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      ptr        <= 1'b0;
    end else if (grant) begin
      rsp_result <= core_result;
      rsp_id     <= gnt_id;
      rsp_err    <= core_div_zero;
      ptr        <= ~gnt_id;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*4-1:0] req_opcode;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t tbl [16];

  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = v;
    req_opcode[i*4 +: 4] = op;
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] r, input logic e);
    chk({tag, "_valid"},  32'(rsp_valid), 32'(v));
    chk({tag, "_id"},     32'(rsp_id),    32'(id));
    chk({tag, "_result"}, rsp_result,     r);
    chk({tag, "_err"},    32'(rsp_err),   32'(e));
  endtask

  initial begin
    logic exp_id [4];
    exp_id[0] = 1'b1; exp_id[1] = 1'b0; exp_id[2] = 1'b1; exp_id[3] = 1'b0;

    tbl[0]  = '{OP_DIV,  32'd100,        32'd0,          32'hFFFFFFFF, 1'b1};
    tbl[1]  = '{OP_SHL,  32'd1,          32'd40,         32'h00000000, 1'b0};
    tbl[2]  = '{OP_SUB,  32'd0,          32'd1,          32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{OP_SHR,  32'h80000000,   32'd31,         32'h00000001, 1'b0};
    tbl[4]  = '{OP_SHL,  32'd1,          32'd31,         32'h80000000, 1'b0};
    tbl[5]  = '{OP_SHR,  32'd1,          32'd32,         32'h00000000, 1'b0};
    tbl[6]  = '{OP_DIV,  32'd100,        32'd7,          32'd14,       1'b0};
    tbl[7]  = '{OP_MUL,  32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE, 1'b0};
    tbl[8]  = '{OP_INC,  32'hFFFFFFFF,   32'd0,          32'h00000000, 1'b0};
    tbl[9]  = '{OP_DEC,  32'd0,          32'd0,          32'hFFFFFFFF, 1'b0};
    tbl[10] = '{OP_NOT,  32'h0F0F0F0F,   32'd0,          32'hF0F0F0F0, 1'b0};
    tbl[11] = '{OP_NAND, 32'hFF00FF00,   32'h0FF00FF0,   32'hF0FFF0FF, 1'b0};
    tbl[12] = '{OP_XNOR, 32'hF0F0F0F0,   32'hFF00FF00,   32'hF00FF00F, 1'b0};
    tbl[13] = '{OP_NOR,  32'd0,          32'd0,          32'hFFFFFFFF, 1'b0};
    tbl[14] = '{OP_OR,   32'h000000A0,   32'h0000000B,   32'h000000AB, 1'b0};
    tbl[15] = '{OP_BUF,  32'h12345678,   32'hDEADBEEF,   32'h12345678, 1'b0};

    // Reset with both requesters asking: no ready, no grant.
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    tick();
    tick();
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);

    // Single request on requester 0.
    rst = 1'b0;
    set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("single", 1'b1, 1'b0, 32'd12, 1'b0);
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    #1;
    chk("idle_ready", 32'(req_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Contention: pointer sits at 1 after the previous grant to 0.
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_SUB, 32'd10, 32'd3);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 32'(req_ready), exp_id[k] ? 32'h2 : 32'h1);
      tick();
      chk_rsp($sformatf("rr%0d", k), 1'b1, exp_id[k], exp_id[k] ? 32'd7 : 32'd2, 1'b0);
    end

    // Backpressure: hold response; requester 1 operands change while ungranted.
    rsp_ready = 1'b0;
    set_req(1, 1'b1, OP_MUL, 32'd6, 32'd7);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      tick();
      chk_rsp($sformatf("bp%0d", k), 1'b1, 1'b0, 32'd2, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("bp_resume", 1'b1, 1'b1, 32'd42, 1'b0);

    // Operation table driven through requester 0 alone.
    set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
    for (int k = 0; k < 16; k++) begin
      set_req(0, 1'b1, tbl[k].op, tbl[k].a, tbl[k].b);
      #1;
      chk($sformatf("op%0d_ready", k), 32'(req_ready), 32'h1);
      tick();
      chk_rsp($sformatf("op%0d", k), 1'b1, 1'b0, tbl[k].r, tbl[k].e);
    end

    // Reset while FULL with the pointer at 1 discards the response and rewinds the pointer.
    rsp_ready = 1'b0;
    rst       = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd2, 32'd3);
    set_req(1, 1'b1, OP_ADD, 32'd20, 32'd1);
    #1;
    chk("rstfull_ready", 32'(req_ready), 32'd0);
    tick();
    chk_rsp("rstfull", 1'b0, 1'b0, 32'd0, 1'b0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(req_ready), 32'h1);
    tick();
    chk_rsp("post_rst0", 1'b1, 1'b0, 32'd5, 1'b0);
    #1;
    chk("post_rst_ready1", 32'(req_ready), 32'h2);
    tick();
    chk_rsp("post_rst1", 1'b1, 1'b1, 32'd21, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets operand and result width.
REQ-002 Parameter NREQ, default 2, sets the number of requesters (fixed 2 in this revision).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request valid.
REQ-007 req_ready  out  NREQ  per-requester accept; a transfer occurs when valid && ready.
REQ-008 req_a, req_b  in  NREQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_opcode  in  NREQ*4  packed 4-bit opcodes, using the standard 16-op ALU encoding.
REQ-010 rsp_valid  out  1  response holding register is full.
REQ-011 rsp_ready  in  1  downstream accepts the response.
REQ-012 rsp_id  out  1  index of the requester that owns the response.
REQ-013 rsp_result  out  WIDTH  ALU result.
REQ-014 rsp_err  out  1  set for divide by zero.

Function
REQ-015 FSM states SHALL be EMPTY (no response held) and FULL (response held).
- EMPTY -> FULL on grant.
- FULL -> EMPTY on rsp_ready with no new grant.
- FULL -> FULL on rsp_ready with a same-cycle grant.
REQ-016 A grant SHALL occur only when the state is EMPTY or (FULL && rsp_ready), which gives full throughput: one op per cycle under continuous rsp_ready.
REQ-017 Arbitration SHALL be round-robin: the pointer starts at requester 0 and, after each grant, moves to the requester after the one granted.
- A lone valid requester is granted regardless of the pointer.
REQ-018 req_ready SHALL be asserted only for the granted requester, combinationally, in the grant cycle; there is at most one ready per cycle.
REQ-019 Latency: a request granted in cycle N SHALL appear on rsp_* in cycle N+1, registered.
REQ-020 rsp_result, rsp_id and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-021 Opcodes and width rules:
- 0 add, 1 sub, 3 inc, 4 dec: modulo 2^WIDTH.
- 2 mul: low WIDTH bits of the product.
- 5 buffer; 6 not.
- 7-12: and, or, xor, nand, nor, xnor.
- 13/14: logical shift left/right by unsigned req_b; a shift count >= WIDTH gives 0.
- 15: unsigned divide.
REQ-022 Divide with req_b=0 SHALL give rsp_result all ones and rsp_err=1; every other op gives rsp_err=0.
REQ-023 Operand and opcode values SHALL be sampled only in the grant cycle; changes while not granted have no effect.
REQ-024 Requests may be withdrawn before being granted; the pointer SHALL NOT move in cycles without a grant.

Reset
REQ-025 When rst=1 at a clock edge, the following SHALL be set:
- state EMPTY;
- rsp_valid=0, rsp_result=0, rsp_id=0, rsp_err=0;
- round-robin pointer = 0.
REQ-026 While rst=1, req_ready SHALL be 0 and no grant occurs.
REQ-027 Reset asserted mid-operation SHALL discard any held response without a handshake.

Structure
REQ-028 Package alu_pkg SHALL hold the 4-bit opcode localparams (OP_ADD..OP_DIV) and the FSM state typedef.
REQ-029 Sub-module alu_core SHALL be the purely combinational WIDTH-bit datapath: inputs a, b, opcode; outputs result, div_zero.
- It is instantiated once.
- The arbiter drives it from the granted requester's mux.

Verification
REQ-030 Single request: req0 add A=5, B=7 with rsp_ready=1 -> req_ready[0] in cycle N; rsp_valid, rsp_id=0, rsp_result=12 in cycle N+1.
REQ-031 Contention: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one response per cycle; ids alternate.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles after a response -> response held stable, req_ready=0 throughout; grant resumes in the cycle rsp_ready returns to 1.
REQ-033 Boundaries:
- div A=100, B=0 -> result 32'hFFFFFFFF, err=1.
- shl A=1, B=40 -> 0.
- sub 0-1 -> 32'hFFFFFFFF, err=0.
REQ-034 Reset while FULL: rst pulse with rsp_valid=1 -> next cycle rsp_valid=0 and pointer=0; with both requesters then valid, req0 is granted first.
